// File: rtl/icache_4x16.sv
// rtl/icache_4x16.sv - direct-mapped 4-line x 16-bit instruction cache between fetch and instruction RAM
module icache_4x16 #(
  parameter int RAM_LAT = 1,  // 1..4 cycles from ram_rd sampled high to ram_data valid
  parameter int CNT_W   = 8
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic [7:0]       cpu_addr,
  input  logic             cpu_rd,
  input  logic             flush,
  output logic [15:0]      cpu_data,
  output logic             odv,
  output logic             busy,
  output logic [7:0]       ram_addr,
  output logic             ram_rd,
  input  logic [15:0]      ram_data,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_FILL
  } state_t;

  // Wait counter preload; MISS_WAIT leaves when the counter reads zero.
  localparam logic [1:0] WAIT_INIT = 2'(RAM_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  req_addr;
  logic [1:0]  wait_cnt;
  logic [15:0] fill_data;
  logic [3:0]  valid;
  logic [5:0]  tag_mem  [4];
  logic [15:0] line_mem [4];

  logic [1:0]  req_index;
  logic [5:0]  req_tag;
  logic        lookup_hit;
  logic        accept;
  logic        hit_evt;
  logic        miss_evt;
  logic        fill_evt;
  logic        capture_evt;

  // Everything after acceptance works from the latched address only.
  assign req_index   = req_addr[1:0];
  assign req_tag     = req_addr[7:2];
  assign lookup_hit  = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign capture_evt = (state == S_MISS_WAIT) && (wait_cnt == 2'd0);

  assign busy     = (state != S_IDLE);
  assign ram_rd   = (state == S_MISS_REQ);
  assign ram_addr = req_addr;

  // State register.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and single-cycle event strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    fill_evt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_rd) begin
          accept    = 1'b1;
          state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          hit_evt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          miss_evt  = 1'b1;
          state_nxt = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        state_nxt = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (wait_cnt == 2'd0) begin
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        fill_evt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request address is captured once at acceptance and held for the whole transaction.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      req_addr <= 8'h00;
    end else if (accept) begin
      req_addr <= cpu_addr;
    end
  end

  // RAM latency counter: preloaded in MISS_REQ, counted down in MISS_WAIT.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      wait_cnt <= 2'd0;
    end else if (state == S_MISS_REQ) begin
      wait_cnt <= WAIT_INIT;
    end else if ((state == S_MISS_WAIT) && (wait_cnt != 2'd0)) begin
      wait_cnt <= wait_cnt - 2'd1;
    end
  end

  // RAM word is sampled on the edge leaving MISS_WAIT, then written into the line during FILL.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      fill_data <= 16'h0000;
    end else if (capture_evt) begin
      fill_data <= ram_data;
    end
  end

  // Valid bits: flush beats a simultaneous fill, so a line filled under flush stays invalid.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      valid <= 4'b0000;
    end else if (flush) begin
      valid <= 4'b0000;
    end else if (fill_evt) begin
      valid[req_index] <= 1'b1;
    end
  end

  // Tag and data arrays are written on every fill regardless of flush.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      for (int i = 0; i < 4; i++) begin
        tag_mem[i]  <= 6'd0;
        line_mem[i] <= 16'h0000;
      end
    end else if (fill_evt) begin
      tag_mem[req_index]  <= req_tag;
      line_mem[req_index] <= fill_data;
    end
  end

  // Fetch-side output: cleared on acceptance, set by a hit or a fill, held otherwise.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      cpu_data <= 16'h0000;
      odv      <= 1'b0;
    end else if (accept) begin
      odv <= 1'b0;
    end else if (hit_evt) begin
      cpu_data <= line_mem[req_index];
      odv      <= 1'b1;
    end else if (fill_evt) begin
      cpu_data <= fill_data;
      odv      <= 1'b1;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_evt && (hit_cnt != {CNT_W{1'b1}})) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
      if (miss_evt && (miss_cnt != {CNT_W{1'b1}})) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_icache_4x16.sv
// tb/tb_icache_4x16.sv - scoreboard and vector-table bench for icache_4x16
module tb_icache_4x16;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int NV    = 24;

  typedef struct {
    int         dut;
    logic [7:0] addr;
    bit         hit;
    bit         pre_flush;
    int         flush_at;
    bit         noise;
  } vec_t;

  logic        clk;
  logic        clr      [2];
  logic [7:0]  cpu_addr [2];
  logic        cpu_rd   [2];
  logic        flush    [2];
  logic [15:0] cpu_data [2];
  logic        odv      [2];
  logic        busy     [2];
  logic [7:0]  ram_addr [2];
  logic        ram_rd   [2];
  logic [15:0] ram_data [2];
  logic [7:0]  hit_a, miss_a;
  logic [1:0]  hit_b, miss_b;

  logic [15:0] mem [256];
  logic [3:0]  rd_sh [2];
  logic [15:0] sb_a [$];
  logic [15:0] sb_b [$];
  logic        odv_q [2];
  logic [15:0] dq_a, dq_b;
  int          rd_cnt [2];
  logic [7:0]  rd_addr [2];
  int          exp_hit [2];
  int          exp_miss [2];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cur_vec = -1;
  int          rd_base;
  vec_t        tbl [NV];

  icache_4x16 #(.RAM_LAT(LAT_A), .CNT_W(8)) u_dut_a (
    .g_clk(clk), .g_clr(clr[0]), .cpu_addr(cpu_addr[0]), .cpu_rd(cpu_rd[0]), .flush(flush[0]),
    .cpu_data(cpu_data[0]), .odv(odv[0]), .busy(busy[0]), .ram_addr(ram_addr[0]), .ram_rd(ram_rd[0]),
    .ram_data(ram_data[0]), .hit_cnt(hit_a), .miss_cnt(miss_a)
  );

  icache_4x16 #(.RAM_LAT(LAT_B), .CNT_W(2)) u_dut_b (
    .g_clk(clk), .g_clr(clr[1]), .cpu_addr(cpu_addr[1]), .cpu_rd(cpu_rd[1]), .flush(flush[1]),
    .cpu_data(cpu_data[1]), .odv(odv[1]), .busy(busy[1]), .ram_addr(ram_addr[1]), .ram_rd(ram_rd[1]),
    .ram_data(ram_data[1]), .hit_cnt(hit_b), .miss_cnt(miss_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency RAM: data is valid only in the single cycle before the edge that must sample it.
  initial begin
    rd_sh[0] = 4'b0;
    rd_sh[1] = 4'b0;
  end
  always @(posedge clk) begin
    rd_sh[0] <= {rd_sh[0][2:0], ram_rd[0]};
    rd_sh[1] <= {rd_sh[1][2:0], ram_rd[1]};
  end
  always_comb begin
    ram_data[0] = rd_sh[0][LAT_A-1] ? mem[ram_addr[0]] : 16'hDEAD;
    ram_data[1] = rd_sh[1][LAT_B-1] ? mem[ram_addr[1]] : 16'hDEAD;
  end

  function automatic int lat(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int maxc(input int d);
    return (d == 0) ? 255 : 3;
  endfunction

  function automatic logic [31:0] hits(input int d);
    return (d == 0) ? 32'(hit_a) : 32'(hit_b);
  endfunction

  function automatic logic [31:0] misses(input int d);
    return (d == 0) ? 32'(miss_a) : 32'(miss_b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, cur_vec, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every odv rise, checks data hold, counts RAM strobes.
  initial begin
    odv_q[0] = 1'b0; odv_q[1] = 1'b0;
    rd_cnt[0] = 0;   rd_cnt[1] = 0;
    rd_addr[0] = 8'h00; rd_addr[1] = 8'h00;
  end
  always @(negedge clk) begin
    if (odv[0] && !odv_q[0]) begin
      if (sb_a.size() == 0) chk("sb_a_extra_odv", 1, 0);
      else chk("sb_a_data", 32'(cpu_data[0]), 32'(sb_a.pop_front()));
    end
    if (odv[1] && !odv_q[1]) begin
      if (sb_b.size() == 0) chk("sb_b_extra_odv", 1, 0);
      else chk("sb_b_data", 32'(cpu_data[1]), 32'(sb_b.pop_front()));
    end
    if (odv[0] && odv_q[0]) chk("hold_a", 32'(cpu_data[0]), 32'(dq_a));
    if (odv[1] && odv_q[1]) chk("hold_b", 32'(cpu_data[1]), 32'(dq_b));
    odv_q[0] = odv[0]; dq_a = cpu_data[0];
    odv_q[1] = odv[1]; dq_b = cpu_data[1];
    if (ram_rd[0]) begin rd_cnt[0]++; rd_addr[0] = ram_addr[0]; end
    if (ram_rd[1]) begin rd_cnt[1]++; rd_addr[1] = ram_addr[1]; end
  end

  task automatic chk_reset(input int d);
    chk("rst_odv", 32'(odv[d]), 0);
    chk("rst_busy", 32'(busy[d]), 0);
    chk("rst_ram_rd", 32'(ram_rd[d]), 0);
    chk("rst_ram_addr", 32'(ram_addr[d]), 0);
    chk("rst_cpu_data", 32'(cpu_data[d]), 0);
    chk("rst_hit_cnt", hits(d), 0);
    chk("rst_miss_cnt", misses(d), 0);
  endtask

  // One fetch: starts and ends on a falling edge with the cache idle.
  task automatic do_req(input int d, input logic [7:0] a, input bit hit, input int flush_at, input bit noise);
    int lat_exp;
    int rd0;
    int k;
    bit done;
    lat_exp = hit ? 1 : 3 + lat(d);
    rd0 = rd_cnt[d];
    chk("idle_busy", 32'(busy[d]), 0);
    cpu_addr[d] = a;
    cpu_rd[d] = 1'b1;
    if (d == 0) sb_a.push_back(mem[a]); else sb_b.push_back(mem[a]);
    @(posedge clk);
    k = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      flush[d] = 1'b0;
      cpu_addr[d] = 8'($urandom);
      if (k == 0) begin
        chk("odv_cleared", 32'(odv[d]), 0);
        chk("busy_set", 32'(busy[d]), 1);
        cpu_rd[d] = noise;
      end
      if (odv[d]) begin
        done = 1'b1;
        cpu_rd[d] = 1'b0;
      end else begin
        if (k == flush_at) flush[d] = 1'b1;
        @(posedge clk);
        k++;
      end
    end
    cpu_rd[d] = 1'b0;
    chk("latency", k, lat_exp);
    chk("ram_rd_pulses", rd_cnt[d] - rd0, hit ? 0 : 1);
    if (!hit) chk("ram_rd_addr", 32'(rd_addr[d]), 32'(a));
    if (hit) begin
      if (exp_hit[d] < maxc(d)) exp_hit[d]++;
    end else begin
      if (exp_miss[d] < maxc(d)) exp_miss[d]++;
    end
    chk("hit_cnt", hits(d), exp_hit[d]);
    chk("miss_cnt", misses(d), exp_miss[d]);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h3C, 8'(i * 7 + 1)};
    mem[5] = 16'hA5C3;
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b1; cpu_addr[d] = 8'h00; cpu_rd[d] = 1'b0; flush[d] = 1'b0;
      exp_hit[d] = 0; exp_miss[d] = 0;
    end

    //            dut addr   hit   pflush flush_at       noise
    tbl[0]  = '{0, 8'h05, 1'b0, 1'b0, -1,          1'b0};  // cold miss
    tbl[1]  = '{0, 8'h05, 1'b1, 1'b0, -1,          1'b0};  // re-read hit
    tbl[2]  = '{0, 8'h09, 1'b0, 1'b0, -1,          1'b0};  // conflict on index 1
    tbl[3]  = '{0, 8'h05, 1'b0, 1'b0, -1,          1'b0};  // evicted, misses again
    tbl[4]  = '{0, 8'h00, 1'b0, 1'b0, -1,          1'b0};
    tbl[5]  = '{0, 8'h01, 1'b0, 1'b0, -1,          1'b1};
    tbl[6]  = '{0, 8'h02, 1'b0, 1'b0, -1,          1'b0};
    tbl[7]  = '{0, 8'h03, 1'b0, 1'b0, -1,          1'b0};
    tbl[8]  = '{0, 8'h02, 1'b1, 1'b0, -1,          1'b1};
    tbl[9]  = '{0, 8'h02, 1'b0, 1'b1, -1,          1'b0};  // flushed while idle
    tbl[10] = '{0, 8'h02, 1'b1, 1'b0, 0,           1'b0};  // flush during LOOKUP still hits
    tbl[11] = '{0, 8'h02, 1'b0, 1'b0, -1,          1'b0};
    tbl[12] = '{0, 8'h07, 1'b0, 1'b0, 2 + LAT_A,   1'b0};  // flush during FILL
    tbl[13] = '{0, 8'h07, 1'b0, 1'b0, -1,          1'b0};  // line was left invalid
    tbl[14] = '{0, 8'h07, 1'b1, 1'b0, -1,          1'b0};
    tbl[15] = '{1, 8'h05, 1'b0, 1'b0, -1,          1'b0};
    tbl[16] = '{1, 8'h05, 1'b1, 1'b0, -1,          1'b1};
    tbl[17] = '{1, 8'h05, 1'b1, 1'b0, -1,          1'b0};
    tbl[18] = '{1, 8'h05, 1'b1, 1'b0, -1,          1'b1};
    tbl[19] = '{1, 8'h05, 1'b1, 1'b0, -1,          1'b0};
    tbl[20] = '{1, 8'h05, 1'b1, 1'b0, -1,          1'b0};  // fifth hit, counter pinned at 3
    tbl[21] = '{1, 8'h01, 1'b0, 1'b0, -1,          1'b1};
    tbl[22] = '{1, 8'h02, 1'b0, 1'b0, -1,          1'b0};
    tbl[23] = '{1, 8'h03, 1'b0, 1'b0, 2 + LAT_B,   1'b1};  // fourth miss, counter pinned at 3

    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    clr[0] = 1'b0;
    clr[1] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      cur_vec = i;
      if (tbl[i].pre_flush) begin
        flush[tbl[i].dut] = 1'b1;
        @(negedge clk);
        flush[tbl[i].dut] = 1'b0;
      end
      do_req(tbl[i].dut, tbl[i].addr, tbl[i].hit, tbl[i].flush_at, tbl[i].noise);
    end

    // Back-to-back hits with cpu_rd held high: three acceptances in six edges.
    cur_vec = 100;
    rd_base = rd_cnt[0];
    cpu_addr[0] = 8'h07;
    cpu_rd[0] = 1'b1;
    repeat (3) sb_a.push_back(mem[8'h07]);
    repeat (6) @(posedge clk);
    @(negedge clk);
    cpu_rd[0] = 1'b0;
    @(negedge clk);
    chk("b2b_delivered", sb_a.size(), 0);
    chk("b2b_no_ram_rd", rd_cnt[0] - rd_base, 0);
    exp_hit[0] += 3;
    chk("b2b_hit_cnt", hits(0), exp_hit[0]);

    // Reset in the middle of a miss (MISS_WAIT with RAM_LAT=3).
    cur_vec = 101;
    rd_base = rd_cnt[1];
    cpu_addr[1] = 8'h0D;
    cpu_rd[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_rd[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_mid_miss", 32'(busy[1]), 1);
    clr[1] = 1'b1;
    #1;
    chk_reset(1);
    chk("aborted_rd_pulses", rd_cnt[1] - rd_base, 1);
    @(negedge clk);
    clr[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_rd_after_reset", rd_cnt[1] - rd_base, 1);
    chk("no_odv_after_reset", 32'(odv[1]), 0);
    exp_hit[1] = 0;
    exp_miss[1] = 0;
    do_req(1, 8'h0D, 1'b0, -1, 1'b0);
    do_req(1, 8'h05, 1'b0, -1, 1'b0);

    @(negedge clk);
    cur_vec = 102;
    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
